// File: rtl/unit_writeback_buffer_pkg.sv
// Shared types and defaults for the unit writeback buffer.
// One stored entry is the completed instruction id plus its result value.
package unit_writeback_buffer_pkg;

  localparam int WB_DEPTH = 2;
  localparam int ID_W     = 3;
  localparam int XLEN     = 32;

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    id_t             id;
    logic [XLEN-1:0] rd;
  } wb_result_t;

endpackage

// File: rtl/unit_writeback_buffer_if.sv
// Unit result input and writeback output bundle.
// The buffer drives the writeback side; the environment drives the unit side.
interface unit_writeback_buffer_if;
  import unit_writeback_buffer_pkg::*;

  logic            result_valid;
  id_t             result_id;
  logic [XLEN-1:0] result_data;
  logic            result_ready;

  logic            wb_done;
  id_t             wb_id;
  logic [XLEN-1:0] wb_rd;
  logic            wb_ack;

  modport master (
    input  result_valid,
    input  result_id,
    input  result_data,
    output result_ready,
    output wb_done,
    output wb_id,
    output wb_rd,
    input  wb_ack
  );

  modport slave (
    output result_valid,
    output result_id,
    output result_data,
    input  result_ready,
    input  wb_done,
    input  wb_id,
    input  wb_rd,
    output wb_ack
  );

endinterface

// File: rtl/unit_writeback_buffer.sv
// In-order result FIFO between a multi-cycle unit and writeback.
// Head entry is presented as done/id/rd and retired on ack.
module unit_writeback_buffer
  import unit_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  unit_writeback_buffer_if.master wb,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);

  wb_result_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  wb_result_t    entry;

  assign full = (count == (PW+1)'(DEPTH));
  assign push = wb.result_valid & ~full;
  assign pop  = wb.wb_ack & wb.wb_done;

  assign wb.result_ready = ~full;
  assign wb.wb_done      = (count != '0);
  assign wb.wb_id        = mem[rd_ptr].id;
  assign wb.wb_rd        = mem[rd_ptr].rd;
  assign occupancy       = count;

  assign entry.id = wb.result_id;
  assign entry.rd = wb.result_data;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full));

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n) !(pop && count == '0));

  a_head_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    wb.wb_done && !wb.wb_ack && !flush |=>
      $stable(wb.wb_id) && $stable(wb.wb_rd));

endmodule

// File: tb/tb_unit_writeback_buffer.sv
// Scoreboard bench for unit_writeback_buffer.
// A queue model predicts head, occupancy and ready every cycle.
module tb_unit_writeback_buffer;
  import unit_writeback_buffer_pkg::*;

  localparam int DEPTH = WB_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;
  wb_result_t q[$];

  unit_writeback_buffer_if bus();

  unit_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wb        (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(bit v, id_t id, logic [XLEN-1:0] d, bit a, bit f);
    wb_result_t e;
    bit full;
    bus.result_valid = v;
    bus.result_id    = id;
    bus.result_data  = d;
    bus.wb_ack       = a;
    flush            = f;
    @(negedge clk);
    check("done", 64'(bus.wb_done), 64'(q.size() != 0));
    check("occ", 64'(occupancy), 64'(q.size()));
    check("ready", 64'(bus.result_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      check("id", 64'(bus.wb_id), 64'(q[0].id));
      check("rd", 64'(bus.wb_rd), 64'(q[0].rd));
    end
    e.id = id;
    e.rd = d;
    full = (q.size() == DEPTH);
    if (f) begin
      q.delete();
    end else begin
      if (a && q.size() != 0) void'(q.pop_front());
      if (v && !full) q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.result_valid = 1'b0;
    bus.wb_ack       = 1'b0;
    flush            = 1'b0;
  endtask

  initial begin
    bus.result_valid = 1'b0;
    bus.result_id    = '0;
    bus.result_data  = '0;
    bus.wb_ack       = 1'b0;

    #8;
    check("rst_done", 64'(bus.wb_done), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_ready", 64'(bus.result_ready), 64'(1));
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first push visible next cycle
    cyc(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    check("first_done", 64'(bus.wb_done), 64'(1));
    check("first_id", 64'(bus.wb_id), 64'(3));
    check("first_rd", 64'(bus.wb_rd), 64'hDEADBEEF);
    check("first_occ", 64'(occupancy), 64'(1));
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // fill, hold, drain
    cyc(1'b1, 3'd1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 32'h22, 1'b0, 1'b0);
    check("full_ready", 64'(bus.result_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
      check("hold_id", 64'(bus.wb_id), 64'(1));
    end
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    check("drain_id", 64'(bus.wb_id), 64'(2));
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // push refused when full even with ack
    cyc(1'b1, 3'd1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 3'd3, 32'h33, 1'b1, 1'b0);
    check("refuse_occ", 64'(occupancy), 64'(1));
    check("refuse_id", 64'(bus.wb_id), 64'(2));
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // streaming push+ack with pointer wrap
    cyc(1'b1, 3'd7, 32'h700, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, id_t'(i % 8), 32'h1000 + 32'(i), 1'b1, 1'b0);
      check("stream_occ", 64'(occupancy), 64'(1));
    end
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // flush beats a concurrent push
    cyc(1'b1, 3'd1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 32'h22, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 32'h55, 1'b0, 1'b1);
    check("flush_done", 64'(bus.wb_done), 64'(0));
    check("flush_occ", 64'(occupancy), 64'(0));
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    // async reset mid-stream
    cyc(1'b1, 3'd4, 32'h44, 1'b0, 1'b0);
    cyc(1'b1, 3'd6, 32'h66, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_done", 64'(bus.wb_done), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_ready", 64'(bus.result_ready), 64'(1));
    q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 3'd2, 32'hABC, 1'b0, 1'b0);
    check("post_id", 64'(bus.wb_id), 64'(2));
    cyc(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
